// File: rtl/freq_meter.sv
// Frequency / period meter for a looped-back square wave.
// Ports: clk, rst (async high), en, sig_in (async) ->
//   freq_count/freq_valid/ovf (gated edge count),
//   period/period_valid/no_signal (rise-to-rise distance).
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 60000000,
   parameter int          CNT_W       = 26,
   parameter int          PER_W       = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_count,
   output logic             freq_valid,
   output logic             ovf,
   output logic [PER_W-1:0] period,
   output logic             period_valid,
   output logic             no_signal
);

   localparam logic [31:0] GATE_LAST =
      32'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX =
      {CNT_W{1'b1}};
   localparam logic [PER_W-1:0] PER_MAX =
      {PER_W{1'b1}};

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             win_end;
   logic             run;
   logic             sync1;
   logic             sync2;
   logic             prev;
   logic             rise;
   logic [31:0]      gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             sat;
   logic             sat_next;
   logic [PER_W-1:0] timer;
   logic             have_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      win_end   = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = GATE;
         end
         GATE: begin
            if (!en)
               state_nxt = IDLE;
            else if (gate_cnt == GATE_LAST)
               win_end = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign run = (state == GATE) && en;

   // Count including this cycle's rise, so a rise
   // in the closing cycle lands in the report.
   always_comb begin
      cnt_next = edge_cnt;
      if (rise && (edge_cnt != CNT_MAX))
         cnt_next = edge_cnt + CNT_W'(1);
   end

   // A count pinned at max means the true count
   // may be higher, so reaching it flags overflow.
   assign sat_next = sat | (cnt_next == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
         freq_count <= '0;
         freq_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         freq_valid <= win_end;
         if (win_end) begin
            freq_count <= cnt_next;
            ovf        <= sat_next;
         end
         if (run && !win_end) begin
            gate_cnt <= gate_cnt + 32'd1;
            edge_cnt <= cnt_next;
            sat      <= sat_next;
         end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
         end
      end
   end

   // Timer restarts at 1 on a rise, so at the next
   // rise it holds the exact rise-to-rise distance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer        <= '0;
         have_edge    <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         no_signal    <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!en) begin
            timer     <= '0;
            have_edge <= 1'b0;
         end else if (rise) begin
            timer     <= PER_W'(1);
            have_edge <= 1'b1;
            no_signal <= 1'b0;
            if (have_edge) begin
               period       <= timer;
               period_valid <= 1'b1;
            end
         end else if (timer == PER_MAX) begin
            no_signal <= 1'b1;
            have_edge <= 1'b0;
         end else begin
            timer <= timer + PER_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a short
// gate window and narrow counters to reach corners.
module tb_freq_meter;

   localparam int G  = 300;
   localparam int CW = 6;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          sig_in;
   logic [CW-1:0] freq_count;
   logic          freq_valid;
   logic          ovf;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          no_signal;

   freq_meter #(
      .GATE_CYCLES(G),
      .CNT_W(CW),
      .PER_W(PW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .sig_in(sig_in),
      .freq_count(freq_count),
      .freq_valid(freq_valid),
      .ovf(ovf),
      .period(period),
      .period_valid(period_valid),
      .no_signal(no_signal)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc    = 0;
   int fv_n   = 0;
   int fv_cyc = 0;
   int fv_cnt = 0;
   int fv_ovf = 0;
   int pv_n   = 0;
   int pv_cyc = 0;
   int pv_val = 0;
   bit fv_d   = 1'b0;
   bit pv_d   = 1'b0;
   bit chk_q  = 1'b0;
   int q[$];

   int cur_p = 10;
   int cur_h = 5;
   int ph    = 0;

   task automatic chk(input string nm,
                      input longint act,
                      input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   // Output monitor, sampled 1 time unit after
   // each rising edge; cyc numbers the edges.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (freq_valid) begin
         chk("fv_width", fv_d, 0);
         fv_n++;
         fv_cyc = cyc;
         fv_cnt = int'(freq_count);
         fv_ovf = int'(ovf);
      end
      if (period_valid) begin
         chk("pv_width", pv_d, 0);
         pv_n++;
         pv_cyc = cyc;
         pv_val = int'(period);
         if (chk_q) begin
            if (q.size() == 0)
               chk("rnd_period_extra", period, -1);
            else
               chk("rnd_period", period, q.pop_front());
         end
      end
      fv_d = freq_valid;
      pv_d = period_valid;
   end

   task automatic step();
      @(negedge clk);
      sig_in = (ph < cur_h);
      ph++;
      if (ph >= cur_p) ph = 0;
   endtask

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         sig_in = v;
      end
   endtask

   task automatic run_fv(input int target,
                         input int budget);
      int k;
      k = 0;
      while (fv_n < target && k < budget) begin
         step();
         k++;
      end
      if (fv_n < target)
         chk("fv_timeout", fv_n, target);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_freq_count"}, freq_count, 0);
      chk({tag, "_freq_valid"}, freq_valid, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_period_valid"}, period_valid, 0);
      chk({tag, "_no_signal"}, no_signal, 0);
   endtask

   typedef struct {
      int p;
      int h;
      int cnt;
      int ov;
   } vec_t;

   vec_t tv[7];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int c_en;
      int p0;
      int n0;
      int ns_cyc;
      int hi;
      int lo;
      int k;

      // window G=300: count = min(G/p, 63)
      tv[0] = '{p: 10,  h: 5,  cnt: 30, ov: 0};
      tv[1] = '{p: 4,   h: 2,  cnt: 63, ov: 1};
      tv[2] = '{p: 20,  h: 10, cnt: 15, ov: 0};
      tv[3] = '{p: 5,   h: 2,  cnt: 60, ov: 0};
      tv[4] = '{p: 6,   h: 3,  cnt: 50, ov: 0};
      tv[5] = '{p: 150, h: 75, cnt: 2,  ov: 0};
      tv[6] = '{p: 12,  h: 6,  cnt: 25, ov: 0};

      rst    = 1'b1;
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");

      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      en    = 1'b1;
      c_en  = cyc;
      cur_p = 10;
      cur_h = 5;
      ph    = 0;
      run_fv(fv_n + 1, 2 * G);
      chk("first_fv_latency", fv_cyc - c_en, G + 1);
      chk("first_fv_count", fv_cnt, 30);
      chk("first_fv_ovf", fv_ovf, 0);
      chk("first_period", pv_val, 10);

      for (int i = 0; i < 7; i++) begin
         cur_p = tv[i].p;
         cur_h = tv[i].h;
         ph    = 0;
         run_fv(fv_n + 1, G + 20);
         run_fv(fv_n + 1, G + 20);
         chk($sformatf("tab_cnt_p%0d", tv[i].p),
             fv_cnt, tv[i].cnt);
         chk($sformatf("tab_ovf_p%0d", tv[i].p),
             fv_ovf, tv[i].ov);
         chk($sformatf("tab_period_p%0d", tv[i].p),
             pv_val, tv[i].p);
      end

      // Loss of signal after the last rise.
      ns_cyc = -1;
      k = 0;
      while (ns_cyc < 0 && k < 400) begin
         @(negedge clk);
         sig_in = 1'b0;
         if (no_signal) ns_cyc = cyc;
         k++;
      end
      if (ns_cyc < 0)
         chk("ns_timeout", no_signal, 1);
      else
         chk("ns_delay", ns_cyc - pv_cyc, 255);

      cur_p = 10;
      cur_h = 5;
      ph    = 0;
      p0    = pv_n;
      repeat (8) step();
      chk("ns_clear", no_signal, 0);
      chk("ns_first_no_pv", pv_n, p0);
      repeat (12) step();
      chk("ns_second_pv", pv_n, p0 + 1);
      chk("ns_second_period", pv_val, 10);

      // Drop en part-way into a clean window.
      run_fv(fv_n + 1, G + 20);
      run_fv(fv_n + 1, G + 20);
      k = fv_cyc;
      while (cyc < k + 600) step();
      en = 1'b0;
      n0 = fv_n;
      repeat (700) step();
      chk("en_drop_no_fv", fv_n, n0);
      chk("en_drop_hold_cnt", freq_count, 30);
      chk("en_drop_hold_ovf", ovf, 0);
      en   = 1'b1;
      c_en = cyc;
      run_fv(fv_n + 1, G + 20);
      chk("en_back_latency", fv_cyc - c_en, G + 1);
      chk("en_back_count", fv_cnt, 30);

      // Random legal high/low times vs the queue of
      // expected rise-to-rise distances.
      drive(1'b0, 4);
      en = 1'b0;
      drive(1'b0, 3);
      en = 1'b1;
      drive(1'b0, 2);
      p0    = pv_n;
      chk_q = 1'b1;
      for (int i = 0; i < 40; i++) begin
         hi = int'($urandom_range(2, 6));
         lo = int'($urandom_range(2, 8));
         q.push_back(hi + lo);
         drive(1'b1, hi);
         drive(1'b0, lo);
      end
      drive(1'b1, 2);
      drive(1'b0, 6);
      chk("rnd_queue_drained", q.size(), 0);
      chk("rnd_pv_count", pv_n - p0, 40);
      chk_q = 1'b0;

      // Reset in the middle of a window and period.
      cur_p = 10;
      cur_h = 5;
      ph    = 0;
      run_fv(fv_n + 1, G + 20);
      repeat (150) step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      drive(1'b0, 3);
      @(negedge clk);
      rst  = 1'b0;
      c_en = cyc;
      p0   = pv_n;
      n0   = fv_n;
      ph   = 0;
      repeat (8) step();
      chk("rst_first_rise_no_pv", pv_n, p0);
      repeat (12) step();
      chk("rst_second_rise_pv", pv_n, p0 + 1);
      chk("rst_period", pv_val, 10);
      run_fv(n0 + 1, G + 20);
      chk("rst_fv_latency", fv_cyc - c_en, G + 1);
      chk("rst_fv_count", fv_cnt, 30);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Frequency and period measurement block: the receiving end of the project's programmable square-wave divider. It takes an external square wave on one input, synchronises it to the 60 MHz system clock, and reports two results. The first is the number of rising edges in a fixed gate window. The second is the clk-cycle distance between consecutive rising edges. It sits beside the divider in the top-level so the generated clock can be looped back and self-checked on silicon.

## Interface
- GATE_CYCLES, 60000000: gate window length in clk cycles (1 s at 60 MHz); legal range is 2 to 2^32−1.
- CNT_W, 26: width of the edge-count result.
- PER_W, 26: width of the period result and timer.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high. Clears all state immediately.
- en  in  1  measurement enable, synchronous to clk.
- sig_in  in  1  measured square wave, asynchronous to clk.
- freq_count  out  CNT_W  rising edges counted in the last completed gate window.
- freq_valid  out  1  one-cycle pulse when freq_count updates.
- ovf  out  1  last completed window saturated freq_count; updates with freq_valid.
- period  out  PER_W  clk cycles between the last two rising edges.
- period_valid  out  1  one-cycle pulse when period updates.
- no_signal  out  1  high when no rising edge has been seen for 2^PER_W−1 cycles.

## Operation
- Input path:
  - sig_in passes through a 2-flop synchroniser, then a registered previous-value flop.
  - rise = sync2 & ~prev.
  - Fixed latency from sig_in to rise is 3 clk cycles. It is identical for every edge, so it has no effect on period.
- Gate state machine has two states:
  - IDLE: gate counter and edge counter held at 0. IDLE→GATE when en=1.
  - GATE: gate counter increments every cycle. The edge counter increments on rise and saturates at 2^CNT_W−1; saturation sets an internal sat flag.
  - When the gate counter reaches GATE_CYCLES−1:
    - freq_count gets the edge count, including a rise in that same cycle.
    - ovf gets sat.
    - freq_valid pulses.
    - Both counters and sat clear, and the block stays in GATE. Consecutive windows have no dead cycle.
  - en=0 in GATE: go to IDLE next cycle. The partial window is discarded with no freq_valid, and freq_count/ovf hold their last values.
- Period path runs whenever en=1, independent of the gate:
  - The timer clears to 1 on rise and otherwise increments, saturating at 2^PER_W−1.
  - A have_edge flag is set by the first rise.
  - On a rise with have_edge=1: period gets the timer value, which equals the cycle distance between the two rises, and period_valid pulses.
  - When the timer saturates: no_signal=1 and have_edge clears. The next rise clears no_signal and re-arms the timer, but does not produce period_valid.
  - en=0 clears the timer and have_edge; period and no_signal hold.
- Input limits: sig_in must be high and low for at least 2 clk cycles each. Faster inputs alias, and the result is unspecified but must not lock up.

## Timing
- Reset values: freq_count=0, freq_valid=0, ovf=0, period=0, period_valid=0, no_signal=0, state=IDLE, synchroniser flops=0.
- First freq_valid comes GATE_CYCLES cycles after the first clk edge with en=1 sampled high, then every GATE_CYCLES cycles after that.
- period_valid comes 3 cycles after the sampled sig_in rise that closes the period.
- All outputs are registered, and valid pulses last exactly one cycle.
- Simultaneous events:
  - A rise in the final gate cycle counts toward the closing window.
  - A rise in the first cycle of the next window counts toward the new window.
  - Saturation and window end in the same cycle report ovf=1.
- rst asserted mid-window or mid-period: all outputs go to their reset values immediately, with no pulse emitted. After release, the block restarts from IDLE.

## Test plan
- GATE_CYCLES=1000, sig_in period 10 clk at 50% duty, en=1 → freq_valid every 1000 cycles with freq_count=100 and ovf=0; period_valid every 10 cycles with period=10.
- GATE_CYCLES=1000, sig_in period 4 clk (2 high/2 low, fastest legal rate) → freq_count=250 every window; period=4.
- CNT_W=6, GATE_CYCLES=1000, sig_in period 10 → freq_count=63 and ovf=1. Then change to period 20 → next full window reports freq_count=50 and ovf=0.
- PER_W=8, sig_in held low → no_signal=1 at 255 cycles after the last rise. Resume at period 10 → the first rise clears no_signal with no period_valid; the second rise gives period=10.
- GATE_CYCLES=1000, en dropped at cycle 600 of a window → no freq_valid and freq_count holds its old value. Re-assert en → the next freq_valid comes exactly 1000 cycles later with a full count.
- rst pulsed mid-window and mid-period → all outputs are 0 in the same cycle. After release with en=1, the first freq_valid comes GATE_CYCLES cycles later, and period_valid only after two rises.
